// File: rtl/pipe_chain_if.sv
// pipe_chain_if: entry, stall/flush, drain, forwarding-query and occupancy signals of pipe_chain.
interface pipe_chain_if #(
   parameter int WD     = 32,
   parameter int WAD    = 5,
   parameter int STAGES = 3
);
   localparam int IW = $clog2(STAGES);
   localparam int OW = $clog2(STAGES + 1);
   logic              in_valid;
   logic              in_regwrite;
   logic [WD-1:0]     in_payload;
   logic [WAD-1:0]    in_rd;
   logic [STAGES-1:0] stall_req;
   logic [STAGES-1:0] flush;
   logic              in_ready;
   logic              out_valid;
   logic              out_regwrite;
   logic [WD-1:0]     out_payload;
   logic [WAD-1:0]    out_rd;
   logic [WAD-1:0]    query_rs1;
   logic [WAD-1:0]    query_rs2;
   logic              hit1;
   logic              hit2;
   logic [IW-1:0]     hit1_idx;
   logic [IW-1:0]     hit2_idx;
   logic [WD-1:0]     fwd1_data;
   logic [WD-1:0]     fwd2_data;
   logic [OW-1:0]     occ;
   modport master (
      output in_valid, in_regwrite, in_payload, in_rd, stall_req, flush, query_rs1, query_rs2,
      input  in_ready, out_valid, out_regwrite, out_payload, out_rd,
      input  hit1, hit2, hit1_idx, hit2_idx, fwd1_data, fwd2_data, occ
   );
   modport slave (
      input  in_valid, in_regwrite, in_payload, in_rd, stall_req, flush, query_rs1, query_rs2,
      output in_ready, out_valid, out_regwrite, out_payload, out_rd,
      output hit1, hit2, hit1_idx, hit2_idx, fwd1_data, fwd2_data, occ
   );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: in-order pipeline with per-stage stall/flush, register-forwarding match and occupancy count.
module pipe_chain #(
   parameter int WD     = 32,
   parameter int WAD    = 5,
   parameter int STAGES = 3
) (
   input logic         clk,
   input logic         rst,
   pipe_chain_if.slave bus
);
   localparam int IW = $clog2(STAGES);
   localparam int OW = $clog2(STAGES + 1);
   logic [STAGES-1:0] v_q, v_d, rw_q, rw_d, hold, bub;
   logic [WAD-1:0]    rd_q  [STAGES];
   logic [WAD-1:0]    rd_d  [STAGES];
   logic [WD-1:0]     pay_q [STAGES];
   logic [WD-1:0]     pay_d [STAGES];
   logic [OW-1:0]     occ_q, occ_d;
   // hold[i]: some stage at or above i requests a stall; bub[i]: stage i sits just above the highest one
   always_comb begin
      for (int i = 0; i < STAGES; i++) hold[i] = |(bus.stall_req >> i);
      bub[0] = 1'b0;
      for (int i = 1; i < STAGES; i++) bub[i] = bus.stall_req[i-1] & ~hold[i];
   end
   always_comb begin
      v_d   = v_q;
      rw_d  = rw_q;
      rd_d  = rd_q;
      pay_d = pay_q;
      if (!hold[0]) begin
         v_d[0]   = bus.in_valid;
         rw_d[0]  = bus.in_regwrite;
         rd_d[0]  = bus.in_rd;
         pay_d[0] = bus.in_payload;
      end else
         v_d[0] = v_q[0] & ~bus.flush[0];
      for (int i = 1; i < STAGES; i++)
         if (hold[i])
            v_d[i] = v_q[i] & ~bus.flush[i];
         else begin
            v_d[i]   = v_q[i-1] & ~bus.flush[i-1] & ~bub[i];
            rw_d[i]  = rw_q[i-1];
            rd_d[i]  = rd_q[i-1];
            pay_d[i] = pay_q[i-1];
         end
   end
   // entries only disappear by flush or by leaving the oldest stage; bubbles never destroy content
   always_comb begin
      occ_d = occ_q + OW'(bus.in_valid & ~hold[0]);
      for (int i = 0; i < STAGES; i++)
         occ_d = occ_d - OW'(v_q[i] & (bus.flush[i] | ((i == STAGES - 1) & ~hold[i])));
   end
   // scanning oldest to youngest lets the youngest match win
   always_comb begin
      bus.hit1      = 1'b0;
      bus.hit1_idx  = '0;
      bus.fwd1_data = '0;
      bus.hit2      = 1'b0;
      bus.hit2_idx  = '0;
      bus.fwd2_data = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (v_q[i] && rw_q[i] && rd_q[i] != '0 && rd_q[i] == bus.query_rs1) begin
            bus.hit1      = 1'b1;
            bus.hit1_idx  = IW'(i);
            bus.fwd1_data = pay_q[i];
         end
         if (v_q[i] && rw_q[i] && rd_q[i] != '0 && rd_q[i] == bus.query_rs2) begin
            bus.hit2      = 1'b1;
            bus.hit2_idx  = IW'(i);
            bus.fwd2_data = pay_q[i];
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q   <= '0;
         rw_q  <= '0;
         occ_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            rd_q[i]  <= '0;
            pay_q[i] <= '0;
         end
      end else begin
         v_q   <= v_d;
         rw_q  <= rw_d;
         rd_q  <= rd_d;
         pay_q <= pay_d;
         occ_q <= occ_d;
      end
   end
   assign bus.in_ready     = ~hold[0];
   assign bus.out_valid    = v_q[STAGES-1];
   assign bus.out_regwrite = rw_q[STAGES-1];
   assign bus.out_rd       = rd_q[STAGES-1];
   assign bus.out_payload  = pay_q[STAGES-1];
   assign bus.occ          = occ_q;
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed stimulus, per-cycle comparison against a stage-list model, plus literal checks.
module tb_pipe_chain;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   pipe_chain_if #(.WD(32), .WAD(5), .STAGES(3)) bus();
   pipe_chain #(.WD(32), .WAD(5), .STAGES(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct packed {
      logic        v;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] p;
   } ent_t;
   ent_t m [3];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic int m_occ();
      int c = 0;
      for (int i = 0; i < 3; i++) c += int'(m[i].v);
      return c;
   endfunction
   function automatic void m_match(input logic [4:0] q, output logic h, output logic [1:0] ix,
                                   output logic [31:0] d);
      h = 1'b0; ix = '0; d = '0;
      for (int i = 0; i < 3; i++)
         if (!h && m[i].v && m[i].rw && q != 5'd0 && m[i].rd == q) begin
            h = 1'b1; ix = 2'(i); d = m[i].p;
         end
   endfunction
   // model: held stages keep (minus flush), one bubble above the highest stall, everything else shifts
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) m[i] = '0;
      end else begin
         automatic ent_t n [3];
         automatic int   h = -1;
         for (int i = 0; i < 3; i++) if (bus.stall_req[i]) h = i;
         for (int j = 0; j < 3; j++) begin
            if (j <= h) begin
               n[j] = m[j]; n[j].v = m[j].v & ~bus.flush[j];
            end else if (h >= 0 && j == h + 1)
               n[j] = '0;
            else if (j == 0)
               n[j] = {bus.in_valid, bus.in_regwrite, bus.in_rd, bus.in_payload};
            else begin
               n[j] = m[j-1]; n[j].v = m[j-1].v & ~bus.flush[j-1];
            end
         end
         for (int i = 0; i < 3; i++) m[i] = n[i];
      end
   end
   always @(negedge clk) begin
      logic h; logic [1:0] ix; logic [31:0] d;
      chk("in_ready", bus.in_ready, {31'b0, ~|bus.stall_req});
      chk("out_valid", bus.out_valid, m[2].v);
      if (m[2].v) begin
         chk("out_payload", bus.out_payload, m[2].p);
         chk("out_rd", bus.out_rd, m[2].rd);
         chk("out_regwrite", bus.out_regwrite, m[2].rw);
      end
      chk("occ", bus.occ, m_occ());
      m_match(bus.query_rs1, h, ix, d);
      chk("hit1", bus.hit1, h);
      chk("hit1_idx", bus.hit1_idx, ix);
      chk("fwd1_data", bus.fwd1_data, d);
      m_match(bus.query_rs2, h, ix, d);
      chk("hit2", bus.hit2, h);
      chk("hit2_idx", bus.hit2_idx, ix);
      chk("fwd2_data", bus.fwd2_data, d);
   end
   task automatic drv(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] p,
                      input logic [2:0] st, input logic [2:0] fl);
      bus.in_valid = v; bus.in_regwrite = rw; bus.in_rd = rd; bus.in_payload = p;
      bus.stall_req = st; bus.flush = fl;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [2:0] stab [8];
      logic [2:0] ftab [5];
      stab = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b001, 3'b000, 3'b011};
      ftab = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001};
      rst = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      bus.query_rs1 = '0; bus.query_rs2 = '0;
      tick();
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst occ", bus.occ, 0);
      chk("rst hit1", bus.hit1, 0);
      tick();
      rst = 1'b1;
      // single entry latency
      drv(1, 1, 3, 32'hA5, 0, 0); tick();
      chk("lat occ0", bus.occ, 1); chk("lat ov0", bus.out_valid, 0);
      drv(0, 0, 0, 0, 0, 0); tick();
      chk("lat occ1", bus.occ, 1);
      tick();
      chk("lat ov2", bus.out_valid, 1); chk("lat pay", bus.out_payload, 32'hA5);
      chk("lat rd", bus.out_rd, 3); chk("lat occ2", bus.occ, 1);
      tick();
      chk("lat ov3", bus.out_valid, 0); chk("lat occ3", bus.occ, 0);
      // stall at stage 1 for two edges
      drv(1, 1, 1, 32'h0A, 0, 0); tick();
      drv(1, 1, 1, 32'h0B, 0, 0); tick();
      drv(1, 1, 1, 32'h0C, 0, 0); tick();
      chk("stall A", bus.out_payload, 32'h0A);
      drv(1, 1, 9, 32'hDD, 3'b010, 0); #1;
      chk("stall in_ready", bus.in_ready, 0);
      tick();
      chk("stall bub1", bus.out_valid, 0); chk("stall occ", bus.occ, 2);
      tick();
      chk("stall bub2", bus.out_valid, 0);
      drv(0, 0, 0, 0, 0, 0); tick();
      chk("stall B v", bus.out_valid, 1); chk("stall B", bus.out_payload, 32'h0B);
      tick();
      chk("stall C", bus.out_payload, 32'h0C);
      tick();
      chk("stall drained", bus.out_valid, 0); chk("stall occ0", bus.occ, 0);
      // flush beats hold on stage 0
      drv(1, 1, 2, 32'h31, 0, 0); tick();
      drv(1, 1, 2, 32'h32, 0, 0); tick();
      chk("fh occ2", bus.occ, 2);
      drv(0, 0, 0, 0, 3'b001, 3'b001); tick();
      chk("fh occ1", bus.occ, 1); chk("fh out", bus.out_payload, 32'h31);
      drv(0, 0, 0, 0, 0, 0); tick();
      chk("fh gone", bus.out_valid, 0); chk("fh occ0", bus.occ, 0);
      // forwarding priority and rd=0 exclusion
      drv(1, 1, 5, 32'h22, 0, 0); tick();
      drv(1, 1, 0, 32'h33, 0, 0); tick();
      drv(1, 1, 5, 32'h11, 0, 0); tick();
      drv(0, 0, 0, 0, 0, 0);
      bus.query_rs1 = 5; bus.query_rs2 = 0; #1;
      chk("fw hit1", bus.hit1, 1); chk("fw idx1", bus.hit1_idx, 0);
      chk("fw data1", bus.fwd1_data, 32'h11); chk("fw hit2", bus.hit2, 0);
      chk("fw data2", bus.fwd2_data, 0);
      tick();
      chk("fw idx1b", bus.hit1_idx, 1); chk("fw data1b", bus.fwd1_data, 32'h11);
      tick(); tick();
      // valid entry without regwrite never forwards
      drv(1, 0, 7, 32'h77, 0, 0); tick();
      drv(0, 0, 0, 0, 0, 0);
      bus.query_rs1 = 7; #1;
      chk("nrw hit1", bus.hit1, 0); chk("nrw data", bus.fwd1_data, 0); chk("nrw occ", bus.occ, 1);
      tick(); tick(); tick();
      // mixed stalls, flushes and queries
      for (int i = 0; i < 60; i++) begin
         drv(i % 3 != 2, i % 2 == 0, 5'(i * 7), 32'h1000 + i, stab[i % 8], ftab[i % 5]);
         bus.query_rs1 = 5'((i - 1) * 7); bus.query_rs2 = 5'((i - 2) * 7);
         tick();
      end
      drv(0, 0, 0, 0, 0, 0); tick(); tick(); tick();
      // asynchronous reset with a full pipe
      drv(1, 1, 4, 32'h41, 0, 0); tick();
      drv(1, 1, 4, 32'h42, 0, 0); tick();
      drv(1, 1, 4, 32'h43, 0, 0); tick();
      drv(0, 0, 0, 0, 0, 0);
      bus.query_rs1 = 4; #1;
      chk("ar full occ", bus.occ, 3); chk("ar hit pre", bus.hit1, 1);
      rst = 1'b0; #2;
      chk("ar ov", bus.out_valid, 0); chk("ar occ", bus.occ, 0); chk("ar hit", bus.hit1, 0);
      rst = 1'b1;
      tick();
      chk("ar post occ", bus.occ, 0); chk("ar post ov", bus.out_valid, 0);
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter WD, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter WAD, default 5, meaning register-address width.
REQ-003 SHALL have parameter STAGES, default 3 (legal 2..8), meaning pipeline depth; stage 0 is youngest, stage STAGES-1 is oldest.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid, in_regwrite  input  1 each  entry valid / entry writes a register.
REQ-007 SHALL have ports in_payload  input  WD, and in_rd  input  WAD  entry data / destination register.
REQ-008 SHALL have ports stall_req, flush  input  STAGES each  per-stage hold request / per-stage kill.
REQ-009 SHALL have port in_ready  output  1  stage 0 accepts input this cycle.
REQ-010 SHALL have ports out_valid, out_regwrite  output  1, out_payload  output  WD, out_rd  output  WAD  registered contents of stage STAGES-1.
REQ-011 SHALL have ports query_rs1, query_rs2  input  WAD  source registers to match.
REQ-012 SHALL have ports hit1, hit2  output  1; hit1_idx, hit2_idx  output  clog2(STAGES); fwd1_data, fwd2_data  output  WD  match results.
REQ-013 SHALL have port occ  output  clog2(STAGES+1)  count of valid stages.

Function
REQ-014 SHALL hold per stage: valid, regwrite, rd, payload.
REQ-015 SHALL define H = highest index i with stall_req[i]=1; stages 0..H are held, stage H+1 (if < STAGES) receives a bubble (valid=0), stages above H+1 advance.
REQ-016 With no stall_req, every stage j>0 SHALL load stage j-1 and stage 0 SHALL load in_* at each edge.
REQ-017 in_ready SHALL equal ~|stall_req (combinational); in_valid with in_ready=0 is ignored (not captured).
REQ-018 flush[j]=1 SHALL clear the valid of stage j's content at the edge, whether that content is held in j or moved to j+1; flush beats hold.
REQ-019 flush SHALL not clear payload/rd/regwrite fields (only valid).
REQ-020 Latency: an entry captured at edge k SHALL appear on out_* after edge k+STAGES-1 when unstalled and unflushed; out_valid high one cycle per entry.
REQ-021 Oldest stage SHALL drop its content each edge unless held (H = STAGES-1).
REQ-022 hit1 SHALL be 1 iff some stage has valid=1, regwrite=1, rd==query_rs1, rd!=0; same for hit2/query_rs2.
REQ-023 On multiple matches hit*_idx SHALL give the lowest (youngest) index and fwd*_data that stage's payload.
REQ-024 With no hit, hit*_idx and fwd*_data SHALL be 0.
REQ-025 Match outputs SHALL be combinational from current stage state and query inputs.
REQ-026 occ SHALL be a register updated each edge to the number of valid stages after that edge (maintained incrementally, not recomputed from scratch).

Reset
REQ-027 rst=0 SHALL immediately clear all valid, regwrite, rd, payload and occ to 0, independent of clk.
REQ-028 During reset out_valid, hit1, hit2 SHALL be 0; first capture occurs on first edge after rst rises.

Verification (STAGES=3, WD=32, WAD=5)
REQ-029 Latency: in_valid=1, payload 0xA5, rd=3 for one cycle -> out_valid=1, out_payload=0xA5 after 2 more edges, for exactly 1 cycle; occ 1,1,1,0.
REQ-030 Stall: stream entries A,B,C; stall_req[1]=1 for 2 cycles -> in_ready=0, stages 0-1 frozen, stage 2 bubble (out_valid=0 next cycle), resumes in order with no loss or duplication.
REQ-031 Flush+hold: stall_req[0]=1 and flush[0]=1 same edge -> stage 0 valid=0 after edge, occ decremented by 1.
REQ-032 Forwarding: stage0 rd=5 0x11 regwrite=1, stage2 rd=5 0x22 regwrite=1, query_rs1=5 -> hit1=1, hit1_idx=0, fwd1_data=0x11; query_rs2=0 with a valid rd=0 entry -> hit2=0.
REQ-033 Reset mid-operation: full pipe, drop rst between edges -> out_valid, occ, hits go 0 without clock edge; after release pipe empty.
REQ-034 No-regwrite: valid entry rd=7 regwrite=0, query_rs1=7 -> hit1=0, fwd1_data=0.
